// File: rtl/timebase_sched.sv
// Shared prescaler tick (every DIV_VAL+1 cycles) driving NUM_CH countdown channels; done follows expiring tick by 1 cycle.
// No backpressure: strobes sampled every cycle; define TIMEBASE_AUTORELOAD_EN to build periodic mode.
module timebase_sched #(
  parameter int DIV_VAL = 9999999,
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       cancel,
  input  logic [NUM_CH*CNT_W-1:0] load_val,
  input  logic [NUM_CH-1:0]       auto_reload,
  output logic                    tick,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       done
);

  localparam int PW = $clog2(DIV_VAL + 1);
  localparam logic [PW-1:0] DIV_P = PW'(DIV_VAL);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ARMED = 1'b1;

  logic [PW-1:0] presc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      tick  <= 1'b0;
    end else if (presc == DIV_P) begin
      presc <= '0;
      tick  <= 1'b1;
    end else begin
      presc <= presc + 1'b1;
      tick  <= 1'b0;
    end
  end

`ifndef TIMEBASE_AUTORELOAD_EN
  logic unused_auto_reload;
  assign unused_auto_reload = ^auto_reload;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [0:0]       state;
    logic [CNT_W-1:0] remaining;
    logic             done_r;
    logic [CNT_W-1:0] ld;
`ifdef TIMEBASE_AUTORELOAD_EN
    logic [CNT_W-1:0] reload_val;
    logic             periodic;
`endif

    assign ld      = load_val[i*CNT_W +: CNT_W];
    assign busy[i] = (state == ARMED);
    assign done[i] = done_r;

    // cancel beats start beats tick; a start also swallows a coincident tick
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state      <= IDLE;
        remaining  <= '0;
        done_r     <= 1'b0;
`ifdef TIMEBASE_AUTORELOAD_EN
        reload_val <= '0;
        periodic   <= 1'b0;
`endif
      end else begin
        done_r <= 1'b0;
        if (cancel[i]) begin
          state     <= IDLE;
          remaining <= '0;
        end else if (start[i]) begin
          if (ld == '0) begin
            done_r    <= 1'b1;
            state     <= IDLE;
            remaining <= '0;
          end else begin
            state      <= ARMED;
            remaining  <= ld;
`ifdef TIMEBASE_AUTORELOAD_EN
            reload_val <= ld;
            periodic   <= auto_reload[i];
`endif
          end
        end else if (state == ARMED && tick && remaining != '0) begin
          if (remaining == CNT_W'(1)) begin
            done_r <= 1'b1;
`ifdef TIMEBASE_AUTORELOAD_EN
            if (periodic) begin
              remaining <= reload_val;
            end else begin
              state     <= IDLE;
              remaining <= '0;
            end
`else
            state     <= IDLE;
            remaining <= '0;
`endif
          end else begin
            remaining <= remaining - 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_timebase_sched.sv
module tb_timebase_sched;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  start = '0;
  logic [3:0]  cancel = '0;
  logic [31:0] load_val = '0;
  logic [3:0]  auto_reload = '0;
  logic        tick;
  logic [3:0]  busy;
  logic [3:0]  done;

  timebase_sched #(.DIV_VAL(3), .NUM_CH(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cancel(cancel),
    .load_val(load_val), .auto_reload(auto_reload),
    .tick(tick), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int base = 0;
  bit in_rst = 1'b1;
  int exp_q[4][$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected cycle at which done is visible for an arm sampled at edge s with count n
  function automatic int exp_done(int s, int n);
    int rel;
    int first;
    if (n == 0) return s + 1;
    rel = s - base;
    first = base + (rel / 4 + 1) * 4;
    return first + (n - 1) * 4 + 1;
  endfunction

  // Scoreboard: tick phase and done pulses checked every cycle
  always @(negedge clk) begin
    chk("tick_phase", tick, (!in_rst && cyc > base && ((cyc - base) % 4) == 0));
    for (int i = 0; i < 4; i++) begin
      if (exp_q[i].size() == 0) begin
        chk($sformatf("done%0d_spurious", i), done[i], 1'b0);
      end else if (done[i]) begin
        chk($sformatf("done%0d_cycle", i), cyc, exp_q[i].pop_front());
      end else if (exp_q[i][0] < cyc) begin
        chk($sformatf("done%0d_missing", i), cyc, exp_q[i].pop_front());
      end
    end
  end

  task automatic wait_tick();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (tick) return;
    end
    chk("tick_wait", tick, 1'b1);
  endtask

  task automatic wait_done(input int ch);
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done[ch]) return;
    end
    chk("done_wait", done[ch], 1'b1);
  endtask

  task automatic arm(input int ch, input int n, input bit ar, input bit push);
    start[ch] = 1'b1;
    load_val[ch*8 +: 8] = n[7:0];
    auto_reload[ch] = ar;
    if (push) exp_q[ch].push_back(exp_done(cyc, n));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int d0;
    #1;
    chk("rst_tick", tick, 1'b0);
    chk("rst_busy", busy, 4'h0);
    chk("rst_done", done, 4'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1; in_rst = 1'b0; base = cyc;

    repeat (13) @(negedge clk);
    chk("idle_busy", busy, 4'h0);

    // one-shot count 3 armed the cycle after a tick
    wait_tick();
    @(negedge clk); arm(0, 3, 1'b0, 1'b1);
    @(negedge clk); start = '0;
    chk("busy0_armed", busy[0], 1'b1);
    wait_done(0);
    chk("busy0_at_done", busy[0], 1'b0);

    // zero count expires immediately without arming
    @(negedge clk); arm(1, 0, 1'b0, 1'b1);
    @(negedge clk); start = '0;
    chk("done1_zero", done[1], 1'b1);
    chk("busy1_zero", busy[1], 1'b0);
    @(negedge clk);
    chk("busy1_after", busy[1], 1'b0);

    // cancel wins over start; start coincident with tick ignores that tick
    @(negedge clk); arm(2, 5, 1'b0, 1'b0);
    @(negedge clk); start = '0;
    chk("busy2_armed", busy[2], 1'b1);
    wait_tick();
    wait_tick();
    @(negedge clk); arm(2, 9, 1'b0, 1'b0); cancel[2] = 1'b1;
    @(negedge clk); start = '0; cancel = '0;
    chk("busy2_cancel", busy[2], 1'b0);
    repeat (50) @(negedge clk);
    wait_tick();
    arm(2, 2, 1'b0, 1'b1);
    @(negedge clk); start = '0;
    chk("busy2_rearm", busy[2], 1'b1);
    wait_done(2);
    chk("busy2_at_done", busy[2], 1'b0);

    // periodic channel
    @(negedge clk); arm(3, 2, 1'b1, 1'b0);
    d0 = exp_done(cyc, 2);
    exp_q[3].push_back(d0);
`ifdef TIMEBASE_AUTORELOAD_EN
    exp_q[3].push_back(d0 + 8);
    exp_q[3].push_back(d0 + 16);
    exp_q[3].push_back(d0 + 24);
`endif
    @(negedge clk); start = '0; auto_reload = '0;
    while (cyc < d0 + 4) @(negedge clk);
`ifdef TIMEBASE_AUTORELOAD_EN
    chk("busy3_periodic", busy[3], 1'b1);
`else
    chk("busy3_oneshot", busy[3], 1'b0);
`endif
    while (cyc < d0 + 24) @(negedge clk);
    cancel[3] = 1'b1;
    @(negedge clk); cancel = '0;
    chk("busy3_cancel", busy[3], 1'b0);
    repeat (30) @(negedge clk);

    // reset mid-count aborts everything and restarts tick phase
    @(negedge clk);
    start = 4'hF; load_val = {4{8'd4}};
    @(negedge clk); start = '0;
    chk("busy_all", busy, 4'hF);
    repeat (5) @(negedge clk);
    #2; rst_n = 1'b0; in_rst = 1'b1;
    #1;
    chk("midrst_tick", tick, 1'b0);
    chk("midrst_busy", busy, 4'h0);
    chk("midrst_done", done, 4'h0);
    @(negedge clk);
    rst_n = 1'b1; in_rst = 1'b0; base = cyc;
    repeat (40) @(negedge clk);
    chk("post_rst_busy", busy, 4'h0);

    for (int i = 0; i < 4; i++) chk($sformatf("queue%0d_drained", i), exp_q[i].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
